// File: rtl/tagged_array_pkg.sv
// Shared sizing constants and sweep FSM encoding for the tagged array reader.
package tagged_array_pkg;

    localparam int DEPTH = 16;
    localparam int WIDTH = 3;
    localparam int IDXW  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/tag_route.sv
// Splits a registered read result onto the low and high output buses by entry tag.
module tag_route #(
    parameter int WIDTH = tagged_array_pkg::WIDTH
) (
    input  logic             valid_i,
    input  logic             tag_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             rd_tag_o,
    output logic [WIDTH-1:0] rd_low_data_o,
    output logic [WIDTH-1:0] rd_high_data_o
);

    // Everything is forced to zero between pulses so stale data never lingers on the buses.
    always_comb begin
        rd_tag_o       = valid_i & tag_i;
        rd_low_data_o  = (valid_i && !tag_i) ? data_i : '0;
        rd_high_data_o = valid_i ? data_i : '0;
    end

endmodule

// File: rtl/tagged_array_reader.sv
// Tagged register array with a two-stage read path and a full-array sweep that counts tag=1 entries.
module tagged_array_reader #(
    parameter int DEPTH = tagged_array_pkg::DEPTH,
    parameter int WIDTH = tagged_array_pkg::WIDTH,
    parameter int IDXW  = tagged_array_pkg::IDXW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic             wr_tag,
    input  logic [WIDTH-1:0] low_wr_data,
    input  logic [WIDTH-1:0] high_wr_data,
    input  logic             rd_req,
    input  logic [IDXW-1:0]  rd_idx,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic             rd_tag,
    output logic [WIDTH-1:0] rd_low_data,
    output logic [WIDTH-1:0] rd_high_data,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [IDXW:0]    high_count,
    output logic [1:0]       sweep_state
);

    import tagged_array_pkg::*;

    // Handshake: a read is taken at an edge where rd_req=1 and rd_ready=1; the
    // result shows as a one-cycle rd_valid pulse after the following edge.

    sweep_state_e     state_q;
    logic [IDXW-1:0]  ptr_q;
    logic [IDXW:0]    count_q;
    logic [IDXW:0]    count_d;
    logic [IDXW:0]    high_count_q;
    logic             sweep_done_q;

    logic             tags_q [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    logic             snap_valid_q;
    logic             snap_tag_q;
    logic [WIDTH-1:0] snap_data_q;
    logic             out_valid_q;
    logic             out_tag_q;
    logic [WIDTH-1:0] out_data_q;

    logic             rd_accept;
    logic [IDXW-1:0]  snap_idx_d;
    logic [WIDTH-1:0] wr_data_d;

    always_comb begin
        rd_accept  = rd_req && (state_q == ST_IDLE);
        snap_idx_d = (state_q == ST_SWEEP) ? ptr_q : rd_idx;
        wr_data_d  = wr_tag ? high_wr_data : low_wr_data;
        count_d    = count_q + (IDXW+1)'(tags_q[ptr_q]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tags_q[i] <= 1'b0;
                data_q[i] <= '0;
            end
        end else if (wr_en) begin
            tags_q[wr_idx] <= wr_tag;
            data_q[wr_idx] <= wr_data_d;
        end
    end

    // Snapshot stage reads the pre-edge array, so a same-edge write is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_valid_q <= 1'b0;
            snap_tag_q   <= 1'b0;
            snap_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_tag_q    <= 1'b0;
            out_data_q   <= '0;
        end else begin
            snap_valid_q <= rd_accept || (state_q == ST_SWEEP);
            snap_tag_q   <= tags_q[snap_idx_d];
            snap_data_q  <= data_q[snap_idx_d];
            out_valid_q  <= snap_valid_q;
            out_tag_q    <= snap_tag_q;
            out_data_q   <= snap_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            count_q      <= '0;
            high_count_q <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A concurrent external read takes priority over starting a sweep.
                    if (sweep_start && !rd_req) begin
                        state_q <= ST_SWEEP;
                        ptr_q   <= '0;
                        count_q <= '0;
                    end
                end
                ST_SWEEP: begin
                    count_q <= count_d;
                    if (ptr_q == IDXW'(DEPTH - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        ptr_q <= ptr_q + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    high_count_q <= count_q;
                    sweep_done_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_ready    = (state_q == ST_IDLE);
    assign sweep_busy  = (state_q != ST_IDLE);
    assign sweep_done  = sweep_done_q;
    assign high_count  = high_count_q;
    assign sweep_state = state_q;
    assign rd_valid    = out_valid_q;

    tag_route #(
        .WIDTH(WIDTH)
    ) u_tag_route (
        .valid_i        (out_valid_q),
        .tag_i          (out_tag_q),
        .data_i         (out_data_q),
        .rd_tag_o       (rd_tag),
        .rd_low_data_o  (rd_low_data),
        .rd_high_data_o (rd_high_data)
    );

endmodule

// File: tb/tb_tagged_array_reader.sv
// Directed bench for tagged_array_reader: reads, write/read collision, sweeps, reset abort.
module tb_tagged_array_reader;

    localparam int DEPTH = 16;
    localparam int WIDTH = 3;
    localparam int IDXW  = 4;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [IDXW-1:0]  wr_idx;
    logic             wr_tag;
    logic [WIDTH-1:0] low_wr_data;
    logic [WIDTH-1:0] high_wr_data;
    logic             rd_req;
    logic [IDXW-1:0]  rd_idx;
    logic             rd_ready;
    logic             rd_valid;
    logic             rd_tag;
    logic [WIDTH-1:0] rd_low_data;
    logic [WIDTH-1:0] rd_high_data;
    logic             sweep_start;
    logic             sweep_busy;
    logic             sweep_done;
    logic [IDXW:0]    high_count;
    logic [1:0]       dbg_state;

    int total;
    int bad;

    logic             m_tag  [DEPTH];
    logic [WIDTH-1:0] m_data [DEPTH];
    logic [3:0]       exp_q [$];

    tagged_array_reader #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .IDXW (IDXW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_tag       (wr_tag),
        .low_wr_data  (low_wr_data),
        .high_wr_data (high_wr_data),
        .rd_req       (rd_req),
        .rd_idx       (rd_idx),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_low_data  (rd_low_data),
        .rd_high_data (rd_high_data),
        .sweep_start  (sweep_start),
        .sweep_busy   (sweep_busy),
        .sweep_done   (sweep_done),
        .high_count   (high_count),
        .sweep_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_write(input int idx, input logic tag, input logic [WIDTH-1:0] d);
        wr_en  = 1'b1;
        wr_idx = 4'(idx);
        wr_tag = tag;
        if (tag) begin
            high_wr_data = d;
            low_wr_data  = ~d;
        end else begin
            low_wr_data  = d;
            high_wr_data = ~d;
        end
        @(negedge clk);
        wr_en = 1'b0;
        m_tag[idx]  = tag;
        m_data[idx] = d;
    endtask

    task automatic do_read(input int idx, input string name);
        logic             et;
        logic [WIDTH-1:0] ed;
        et = m_tag[idx];
        ed = m_data[idx];
        rd_req = 1'b1;
        rd_idx = 4'(idx);
        @(negedge clk);
        rd_req = 1'b0;
        check({name, "_early_valid"}, 32'(rd_valid), 0);
        @(negedge clk);
        check({name, "_valid"}, 32'(rd_valid), 1);
        check({name, "_tag"}, 32'(rd_tag), 32'(et));
        check({name, "_low"}, 32'(rd_low_data), et ? 0 : 32'(ed));
        check({name, "_high"}, 32'(rd_high_data), 32'(ed));
        @(negedge clk);
        check({name, "_pulse_end"}, 32'(rd_valid), 0);
        check({name, "_idle_low"}, 32'(rd_low_data), 0);
        check({name, "_idle_high"}, 32'(rd_high_data), 0);
    endtask

    task automatic wait_done(input int budget, output int nd);
        nd = 0;
        for (int c = 0; c < budget; c++) begin
            if (sweep_done) nd++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nv;
        int nd;
        logic [3:0] e;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_tag = 1'b0;
        low_wr_data = '0; high_wr_data = '0;
        rd_req = 1'b0; rd_idx = '0; sweep_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m_tag[i]  = 1'b0;
            m_data[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_done", 32'(sweep_done), 0);
        check("rst_high_count", 32'(high_count), 0);
        check("rst_busy", 32'(sweep_busy), 0);
        check("rst_state", 32'(dbg_state), 0);
        check("rst_tag", 32'(rd_tag), 0);
        check("rst_low", 32'(rd_low_data), 0);
        check("rst_high", 32'(rd_high_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(rd_ready), 1);

        // Basic low and high entries
        do_write(3, 1'b0, 3'd5);
        do_read(3, "rd3");
        do_write(7, 1'b1, 3'd6);
        do_read(7, "rd7");
        do_read(9, "rd9_empty");

        // Same-cycle write to the read index returns the old entry
        do_write(2, 1'b0, 3'd1);
        wr_en = 1'b1; wr_idx = 4'd2; wr_tag = 1'b1;
        high_wr_data = 3'd4; low_wr_data = 3'd3;
        rd_req = 1'b1; rd_idx = 4'd2;
        @(negedge clk);
        wr_en = 1'b0; rd_req = 1'b0;
        check("coll_early_valid", 32'(rd_valid), 0);
        @(negedge clk);
        check("coll_valid", 32'(rd_valid), 1);
        check("coll_tag", 32'(rd_tag), 0);
        check("coll_low", 32'(rd_low_data), 1);
        check("coll_high", 32'(rd_high_data), 1);
        m_tag[2] = 1'b1; m_data[2] = 3'd4;
        @(negedge clk);
        do_read(2, "rd2_new");

        // Full sweep with entries 0, 5, 15 tagged high
        do_write(2, 1'b0, 3'd0);
        do_write(7, 1'b0, 3'd2);
        do_write(0, 1'b1, 3'd3);
        do_write(5, 1'b1, 3'd7);
        do_write(15, 1'b1, 3'd2);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({m_tag[i], m_data[i]});
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        nv = 0;
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            check($sformatf("sw_busy_%0d", c), 32'(sweep_busy), (c < 17) ? 1 : 0);
            if (c < 17) check($sformatf("sw_ready_%0d", c), 32'(rd_ready), 0);
            if (rd_valid) begin
                nv++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("sw_tag_%0d", nv), 32'(rd_tag), 32'(e[3]));
                    check($sformatf("sw_high_%0d", nv), 32'(rd_high_data), 32'(e[2:0]));
                    check($sformatf("sw_low_%0d", nv), 32'(rd_low_data), e[3] ? 0 : 32'(e[2:0]));
                end
            end
            if (sweep_done) nd++;
            rd_req = (c < 17);
            rd_idx = 4'(c);
            @(negedge clk);
        end
        rd_req = 1'b0;
        check("sw_valid_count", 32'(nv), 16);
        check("sw_done_count", 32'(nd), 1);
        check("sw_high_count", 32'(high_count), 3);
        check("sw_queue_empty", 32'(exp_q.size()), 0);

        // Writes during a sweep: behind the pointer ignored, ahead counted
        do_write(0, 1'b0, 3'd0);
        do_write(5, 1'b0, 3'd0);
        do_write(15, 1'b0, 3'd0);
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        repeat (8) @(negedge clk);
        do_write(12, 1'b1, 3'd5);
        do_write(4, 1'b1, 3'd3);
        wait_done(25, nd);
        check("mid_done_count", 32'(nd), 1);
        check("mid_high_count", 32'(high_count), 1);

        // sweep_start and rd_req together: read wins, sweep follows
        sweep_start = 1'b1; rd_req = 1'b1; rd_idx = 4'd12;
        @(negedge clk);
        rd_req = 1'b0;
        check("prio_busy_first", 32'(sweep_busy), 0);
        @(negedge clk);
        sweep_start = 1'b0;
        check("prio_busy_second", 32'(sweep_busy), 1);
        check("prio_valid", 32'(rd_valid), 1);
        check("prio_tag", 32'(rd_tag), 1);
        check("prio_high", 32'(rd_high_data), 5);
        check("prio_low", 32'(rd_low_data), 0);
        wait_done(25, nd);
        check("prio_done_count", 32'(nd), 1);
        check("prio_high_count", 32'(high_count), 2);

        // sweep_start dropped after losing to a read
        sweep_start = 1'b1; rd_req = 1'b1; rd_idx = 4'd4;
        @(negedge clk);
        sweep_start = 1'b0; rd_req = 1'b0;
        check("drop_busy_first", 32'(sweep_busy), 0);
        @(negedge clk);
        check("drop_busy_second", 32'(sweep_busy), 0);
        check("drop_valid", 32'(rd_valid), 1);
        check("drop_high", 32'(rd_high_data), 3);

        // Reset in the middle of a sweep
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_busy_before", 32'(sweep_busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(sweep_busy), 0);
        check("abort_ready", 32'(rd_ready), 1);
        check("abort_high_count", 32'(high_count), 0);
        check("abort_valid", 32'(rd_valid), 0);
        @(negedge clk);
        check("abort_busy_next", 32'(sweep_busy), 0);
        check("abort_ready_next", 32'(rd_ready), 1);
        wait_done(25, nd);
        check("abort_no_done", 32'(nd), 0);
        for (int i = 0; i < DEPTH; i++) begin
            m_tag[i]  = 1'b0;
            m_data[i] = '0;
        end
        do_read(12, "rd12_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tagged_array_reader.md
TAGGED_ARRAY_READER -- requirements
Module: tagged_array_reader

Interface
REQ-001 Parameter DEPTH, default 16: number of entries.
REQ-002 Parameter WIDTH, default 3: data bits per entry.
REQ-003 Parameter IDXW, default 4: index width, equal to log2(DEPTH).
REQ-004 clk  in  1  {L}: single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  {L}: synchronous, active-low reset.
REQ-006 wr_en  in  1  {L}: write strobe.
REQ-007 wr_idx  in  IDXW  {L}: write index.
REQ-008 wr_tag  in  1  {L}: entry tag; 0 = low, 1 = high.
REQ-009 low_wr_data  in  WIDTH  {L}: data written when wr_tag=0.
REQ-010 high_wr_data  in  WIDTH  {H}: data written when wr_tag=1.
REQ-011 rd_req  in  1  {L}: read request.
REQ-012 rd_idx  in  IDXW  {L}: read index.
REQ-013 rd_ready  out  1  {L}: rd_req is accepted only in a cycle where this is 1.
REQ-014 rd_valid  out  1  {L}: read result valid, 1-cycle pulse.
REQ-015 rd_tag  out  1  {L}: tag of the returned entry.
REQ-016 rd_low_data  out  WIDTH  {L}: entry data if its tag is 0, else 0.
REQ-017 rd_high_data  out  WIDTH  {H}: entry data regardless of tag.
REQ-018 sweep_start  in  1  {L}: start a full-array sweep.
REQ-019 sweep_busy  out  1  {L}: sweep in progress.
REQ-020 sweep_done  out  1  {L}: 1-cycle pulse when a sweep finishes.
REQ-021 high_count  out  IDXW+1  {L}: number of tag=1 entries found by the last sweep.

Function
REQ-022 Storage: tags[DEPTH] labelled {L}; data[DEPTH] labelled {|i| LH_ARRAY tags,i}.
REQ-023 Write when wr_en=1: tags[wr_idx]<=wr_tag; data[wr_idx]<=(wr_tag ? high_wr_data : low_wr_data).
REQ-024 rd_ready = !sweep_busy.
REQ-025 If rd_req && rd_ready at edge N, then rd_valid=1 after edge N+1, showing the contents sampled at edge N.
REQ-026 A same-cycle write to rd_idx is not visible; the read returns the old entry.
REQ-027 When rd_ready=0, rd_req is ignored and no rd_valid follows.
REQ-028 With rd_valid=0: rd_low_data=0, rd_high_data=0, rd_tag=0.
REQ-029 With rd_tag=1, rd_low_data is 0; high data never reaches an {L} output.
REQ-030 FSM states:
- IDLE: sweep_start=1 goes to SWEEP; ptr<=0; count<=0.
- SWEEP: each cycle issues an internal read of ptr with the same output timing as REQ-025, increments count if tags[ptr]=1, and ptr<=ptr+1. When ptr=DEPTH-1, go to DONE.
- DONE: high_count<=final count; sweep_done=1 for one cycle; return to IDLE.
REQ-031 sweep_busy=1 in SWEEP and DONE.
REQ-032 sweep_start outside IDLE is ignored.
REQ-033 If sweep_start and rd_req occur in the same IDLE cycle, the external read wins; the sweep starts the next cycle when sweep_start is still high, otherwise it is dropped.
REQ-034 Writes are allowed during a sweep. A write to an entry the sweep has already passed does not change count; a write to an entry not yet reached is counted.
REQ-035 ptr is IDXW bits and does not wrap within a sweep; the count arithmetic is IDXW+1 bits, so the maximum is DEPTH.

Reset
REQ-036 rst_n=0 at an edge sets: FSM to IDLE; ptr=0; count=0; high_count=0; rd_valid=0; sweep_done=0; all tags=0; all data=0.
REQ-037 Reset during SWEEP aborts the sweep with no sweep_done pulse.
REQ-038 rd_ready=1 on the first cycle after reset is released.

Structure
REQ-039 DEPTH, WIDTH, IDXW and the FSM state encoding (IDLE=0, SWEEP=1, DONE=2; 2 bits) are defined in the shared package tagged_array_pkg.
REQ-040 One sub-module, tag_route, performs the combinational L/H output split (REQ-016, REQ-017, REQ-028, REQ-029).

Verification
REQ-041 Write idx3 tag0 low=5, then read idx3: rd_valid next cycle; rd_tag=0; rd_low_data=5; rd_high_data=5.
REQ-042 Write idx7 tag1 high=6, then read idx7: rd_tag=1; rd_low_data=0; rd_high_data=6.
REQ-043 Write idx2 tag0 low=1; next cycle write idx2 tag1 high=4 with rd_req idx2 in the same cycle: the read returns tag0, data 1.
REQ-044 Tag entries 0, 5 and 15 as 1, then pulse sweep_start: 16 rd_valid pulses; sweep_done pulses once; high_count=3; rd_req ignored throughout.
REQ-045 Start a sweep; at ptr=8 write idx12 tag1 and idx4 tag1 (tags otherwise 0): high_count=1.
REQ-046 Assert rst_n=0 mid-sweep: no sweep_done; high_count=0; sweep_busy=0 and rd_ready=1 on the cycle after release.
